// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock slice: field select codes, field
// widths and wrap limits, plus the wrap-around field step helper.
package alarm_clock_pkg;

   typedef enum logic [1:0] {
      SELECT_NONE = 2'd0,
      SELECT_SEC  = 2'd1,
      SELECT_MIN  = 2'd2,
      SELECT_HOUR = 2'd3
   } select_e;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   // Step a time field by one, wrapping to zero past max_val.
   function automatic logic [5:0] step_field(input logic [5:0] v, input int max_val);
      return (v == 6'(max_val)) ? 6'd0 : v + 6'd1;
   endfunction

endpackage

// File: rtl/alarm_clock_unit_timekeeper.sv
// Seconds prescaler feeding a 24-hour HH:MM:SS counter; time_clr holds both
// the prescaler and the time at zero.
module timekeeper
   import alarm_clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              time_clr,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   logic [PW-1:0] presc;
   logic          tick;

   // With TICKS_PER_SEC == 1 the prescaler sits at 0 and ticks every cycle.
   assign tick = (presc == PW'(TICKS_PER_SEC - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         sec   <= '0;
         min   <= '0;
         hour  <= '0;
      end else if (time_clr) begin
         presc <= '0;
         sec   <= '0;
         min   <= '0;
         hour  <= '0;
      end else if (tick) begin
         presc <= '0;
         sec   <= SEC_W'(step_field(6'(sec), SEC_MAX));
         if (sec == SEC_W'(SEC_MAX)) begin
            min <= MIN_W'(step_field(6'(min), MIN_MAX));
            if (min == MIN_W'(MIN_MAX))
               hour <= HOUR_W'(step_field(6'(hour), HOUR_MAX));
         end
      end else begin
         presc <= presc + PW'(1);
      end
   end

endmodule

// File: rtl/alarm_clock_unit.sv
// Time-of-day counter with an editable alarm time; alarm_out is a registered
// match of the enabled alarm against the current time.
module alarm_clock_unit
   import alarm_clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              time_clr,
   input  logic              enable,
   input  logic [1:0]        select,
   input  logic              increment,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic [SEC_W-1:0]  alarm_sec,
   output logic [MIN_W-1:0]  alarm_min,
   output logic [HOUR_W-1:0] alarm_hour,
   output logic              alarm_out
);

   logic inc_q;
   logic step;

   timekeeper #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_timekeeper (
      .clk      (clk),
      .reset    (reset),
      .time_clr (time_clr),
      .sec      (sec),
      .min      (min),
      .hour     (hour)
   );

   // One step per increment pulse, however long it is held.
   assign step = increment & ~inc_q;

   // NOTE: every register here, alarm fields included, returns to zero on the
   // asynchronous reset so the block comes up with a known alarm time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inc_q      <= 1'b0;
         alarm_sec  <= '0;
         alarm_min  <= '0;
         alarm_hour <= '0;
         alarm_out  <= 1'b0;
      end else begin
         inc_q     <= increment;
         alarm_out <= enable && (sec == alarm_sec) && (min == alarm_min) && (hour == alarm_hour);
         if (step) begin
            unique case (select_e'(select))
               SELECT_SEC:  alarm_sec  <= SEC_W'(step_field(6'(alarm_sec), SEC_MAX));
               SELECT_MIN:  alarm_min  <= MIN_W'(step_field(6'(alarm_min), MIN_MAX));
               SELECT_HOUR: alarm_hour <= HOUR_W'(step_field(6'(alarm_hour), HOUR_MAX));
               SELECT_NONE: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alarm_clock_unit.sv
// Bench for alarm_clock_unit: a seconds-of-day reference model checked every
// cycle, directed edits and matches, plus a TICKS_PER_SEC=1 day rollover.
module tb_alarm_clock_unit;
   import alarm_clock_pkg::*;

   localparam int TPS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0, time_clr = 1'b1, enable = 1'b0, increment = 1'b0;
   logic [1:0] select = 2'd0;
   logic [5:0] sec, min, alarm_sec, alarm_min;
   logic [4:0] hour, alarm_hour;
   logic       alarm_out;

   logic       reset1 = 1'b0, clr1 = 1'b1;
   logic [5:0] sec1, min1, alarm_sec1, alarm_min1;
   logic [4:0] hour1, alarm_hour1;
   logic       alarm_out1;

   alarm_clock_unit #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .reset(reset), .time_clr(time_clr), .enable(enable),
      .select(select), .increment(increment),
      .sec(sec), .min(min), .hour(hour),
      .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
      .alarm_out(alarm_out)
   );

   alarm_clock_unit #(.TICKS_PER_SEC(1)) dut1 (
      .clk(clk), .reset(reset1), .time_clr(clr1), .enable(1'b0),
      .select(2'd0), .increment(1'b0),
      .sec(sec1), .min(min1), .hour(hour1),
      .alarm_sec(alarm_sec1), .alarm_min(alarm_min1), .alarm_hour(alarm_hour1),
      .alarm_out(alarm_out1)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: time kept as seconds since midnight.
   int m_t = 0, m_p = 0, m_as = 0, m_am = 0, m_ah = 0;
   bit m_inc = 0, m_ao = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_t = 0; m_p = 0; m_as = 0; m_am = 0; m_ah = 0; m_inc = 0; m_ao = 0;
      end else begin
         m_ao = enable && (m_t == m_ah * 3600 + m_am * 60 + m_as);
         if (time_clr) begin
            m_t = 0; m_p = 0;
         end else if (m_p == TPS - 1) begin
            m_p = 0; m_t = (m_t + 1) % 86400;
         end else begin
            m_p++;
         end
         if (increment && !m_inc) begin
            case (select)
               2'd1: m_as = (m_as + 1) % 60;
               2'd2: m_am = (m_am + 1) % 60;
               2'd3: m_ah = (m_ah + 1) % 24;
               default: ;
            endcase
         end
         m_inc = increment;
      end
   end

   bit cmp_on = 0;
   always @(negedge clk) begin
      if (cmp_on) begin
         check("model sec",        sec,        m_t % 60);
         check("model min",        min,        (m_t / 60) % 60);
         check("model hour",       hour,       m_t / 3600);
         check("model alarm_sec",  alarm_sec,  m_as);
         check("model alarm_min",  alarm_min,  m_am);
         check("model alarm_hour", alarm_hour, m_ah);
         check("model alarm_out",  alarm_out,  m_ao);
      end
   end

   task automatic pulse(input int len);
      increment = 1'b1;
      repeat (len) @(negedge clk);
      increment = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " sec"}, sec, 0);
      check({tag, " min"}, min, 0);
      check({tag, " hour"}, hour, 0);
      check({tag, " alarm_sec"}, alarm_sec, 0);
      check({tag, " alarm_min"}, alarm_min, 0);
      check({tag, " alarm_hour"}, alarm_hour, 0);
      check({tag, " alarm_out"}, alarm_out, 0);
   endtask

   initial begin
      fork
         begin : main_seq
            repeat (2) @(negedge clk);
            reset = 1'b1;
            cmp_on = 1;
            @(negedge clk);
            check_all_zero("reset");

            select = SELECT_NONE;
            pulse(1);
            check("none alarm_sec", alarm_sec, 0);

            select = SELECT_SEC;
            pulse(1);
            pulse(1);
            check("two pulses alarm_sec", alarm_sec, 2);
            pulse(3);
            check("held pulse alarm_sec", alarm_sec, 3);
            repeat (56) pulse(1);
            check("alarm_sec at 59", alarm_sec, 59);
            pulse(1);
            check("alarm_sec wrap", alarm_sec, 0);
            check("alarm_sec wrap no carry", alarm_min, 0);
            pulse(1);
            pulse(1);
            check("alarm_sec set 2", alarm_sec, 2);

            // Alarm 00:00:02, enabled, time released from clear.
            enable = 1'b1;
            time_clr = 1'b0;
            repeat (4) @(negedge clk);
            check("match sec reached", sec, 2);
            check("match ao not yet", alarm_out, 0);
            @(negedge clk);
            check("match ao rise", alarm_out, 1);
            @(negedge clk);
            check("match sec 3", sec, 3);
            check("match ao 2nd cycle", alarm_out, 1);
            @(negedge clk);
            check("match ao fall", alarm_out, 0);

            time_clr = 1'b1;
            enable = 1'b0;
            @(negedge clk);
            time_clr = 1'b0;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               check("disabled ao", alarm_out, 0);
            end

            time_clr = 1'b1;
            enable = 1'b1;
            @(negedge clk);
            time_clr = 1'b0;
            repeat (5) @(negedge clk);
            check("mid-match ao high", alarm_out, 1);
            enable = 1'b0;
            @(negedge clk);
            check("enable drop ao low", alarm_out, 0);

            time_clr = 1'b1;
            select = SELECT_MIN;
            pulse(1);
            select = SELECT_HOUR;
            pulse(1);
            check("edit alarm_min", alarm_min, 1);
            check("edit alarm_hour", alarm_hour, 1);
            check("edit alarm_sec kept", alarm_sec, 2);
            repeat (22) pulse(1);
            check("alarm_hour at 23", alarm_hour, 23);
            pulse(1);
            check("alarm_hour wrap", alarm_hour, 0);
            check("alarm_hour wrap no carry", alarm_min, 1);

            // Edits while the time runs; the model covers each cycle.
            time_clr = 1'b0;
            enable = 1'b1;
            select = SELECT_SEC;
            repeat (3) pulse(1);
            select = SELECT_MIN;
            pulse(2);

            @(posedge clk);
            #2 reset = 1'b0;
            #1 check_all_zero("async reset");
            @(negedge clk);
            reset = 1'b1;
            enable = 1'b0;
            repeat (3) @(negedge clk);
         end
         begin : roll_seq
            repeat (2) @(negedge clk);
            reset1 = 1'b1;
            @(negedge clk);
            clr1 = 1'b0;
            @(negedge clk);
            check("tps1 first tick", sec1, 1);
            repeat (86397) @(negedge clk);
            check("roll 23:59:58 hour", hour1, 23);
            check("roll 23:59:58 min", min1, 59);
            check("roll 23:59:58 sec", sec1, 58);
            @(negedge clk);
            check("roll 23:59:59 sec", sec1, 59);
            @(negedge clk);
            check("roll 00:00:00 hour", hour1, 0);
            check("roll 00:00:00 min", min1, 0);
            check("roll 00:00:00 sec", sec1, 0);
            check("roll alarm_out", alarm_out1, 0);
         end
      join
      cmp_on = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
